// File: rtl/crcu_rst_seq_pkg.sv
// Shared types and constants for the reset sequencing controller.
package crcu_rst_seq_pkg;

  localparam int N_DOM_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Sequence direction encoding
  localparam logic OP_UP   = 1'b0;  // release domains, ascending index
  localparam logic OP_DOWN = 1'b1;  // assert domains, descending index

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter used for the post-step delay of each domain.
// Counts down to zero and parks there; a load always wins over counting.
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             CRCU_CLK,
  input  logic             CRCU_RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             cnt_zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load on request, otherwise decrement until zero (no wrap from any value)
  always_ff @(posedge CRCU_CLK or negedge CRCU_RST) begin
    if (!CRCU_RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases (op up) or asserts (op down) a set of domain
// resets one at a time, with a programmable delay after each enabled step.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for seq_start; shadow registers captured on start
// STEP  | drive domain idx (if enabled) and load its delay, else skip
// WAIT  | delay counter running; at zero advance idx or finish
// DONE  | one cycle; done pulses and busy drops on the exit edge
module rst_seq_ctrl
  import crcu_rst_seq_pkg::*;
#(
  parameter  int N_DOM = N_DOM_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
  input  logic                   CRCU_CLK,
  input  logic                   CRCU_RST,
  input  logic                   seq_start,
  input  logic                   seq_op,
  input  logic                   seq_abort,
  input  logic [N_DOM-1:0]       en_mask,
  input  logic [N_DOM*CNT_W-1:0] dly_cfg,
  output logic [N_DOM-1:0]       dom_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err_busy,
  output logic [IDX_W-1:0]       cur_dom
);

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   op_q;
  logic [N_DOM-1:0]       mask_q;
  logic [N_DOM*CNT_W-1:0] dly_q;
  logic [N_DOM-1:0]       dom_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic                   idx_last;
  logic [IDX_W-1:0]       idx_d;
  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_zero;

  assign idx_last = (op_q == OP_DOWN) ? (idx_q == '0)
                                      : (idx_q == IDX_W'(N_DOM - 1));
  assign idx_d    = (op_q == OP_DOWN) ? (idx_q - IDX_W'(1))
                                      : (idx_q + IDX_W'(1));

  // The timer loads on the same edge the enabled domain is driven
  assign tmr_load = (state_q == STEP) && mask_q[idx_q] && !seq_abort;
  assign tmr_val  = dly_q[int'(idx_q)*CNT_W +: CNT_W];

  rst_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .CRCU_CLK (CRCU_CLK),
    .CRCU_RST (CRCU_RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt_zero (tmr_zero)
  );

  // Sequencer FSM with all outputs held in registers
  always_ff @(posedge CRCU_CLK or negedge CRCU_RST) begin
    if (!CRCU_RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= OP_UP;
      mask_q  <= '0;
      dly_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= seq_start && !seq_abort && (state_q != IDLE);
      if (seq_abort) begin
        state_q <= IDLE;
        idx_q   <= '0;
        dom_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (seq_start) begin
              op_q    <= seq_op;
              mask_q  <= en_mask;
              dly_q   <= dly_cfg;
              idx_q   <= (seq_op == OP_DOWN) ? IDX_W'(N_DOM - 1) : '0;
              busy_q  <= 1'b1;
              state_q <= STEP;
            end
          end
          STEP: begin
            if (mask_q[idx_q]) begin
              dom_q[idx_q] <= (op_q == OP_UP);
              state_q      <= WAIT;
            end else if (idx_last) begin
              idx_q   <= '0;
              state_q <= DONE;
            end else begin
              idx_q <= idx_d;
            end
          end
          WAIT: begin
            if (tmr_zero) begin
              if (idx_last) begin
                idx_q   <= '0;
                state_q <= DONE;
              end else begin
                idx_q   <= idx_d;
                state_q <= STEP;
              end
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dom_rst_n = dom_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_busy  = err_q;
  assign cur_dom   = idx_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: directed vector table, hand-written abort and
// reset sequences, then randomized sequences against a schedule model.
module tb_rst_seq_ctrl;

  localparam int N_DOM = 4;
  localparam int CNT_W = 8;
  localparam logic [15:0] NO = 16'hFFFF;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        seq_start = 1'b0;
  logic        seq_op    = 1'b0;
  logic        seq_abort = 1'b0;
  logic [3:0]  en_mask   = '0;
  logic [31:0] dly_cfg   = '0;
  logic [3:0]  dom_rst_n;
  logic        busy, done, err_busy;
  logic [1:0]  cur_dom;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             op;
    logic [3:0]       mask;
    logic [31:0]      cfg;
    bit               pre_abort;
    int               xs;       // edge of an extra seq_start, -1 none
    logic [3:0][15:0] et;       // edge at which each bit toggles, NO none
    int               done_t;
    logic [3:0]       fin;
  } vec_t;

  vec_t vt [11];

  rst_seq_ctrl #(.N_DOM(N_DOM), .CNT_W(CNT_W)) dut (
    .CRCU_CLK  (clk),
    .CRCU_RST  (rst_n),
    .seq_start (seq_start),
    .seq_op    (seq_op),
    .seq_abort (seq_abort),
    .en_mask   (en_mask),
    .dly_cfg   (dly_cfg),
    .dom_rst_n (dom_rst_n),
    .busy      (busy),
    .done      (done),
    .err_busy  (err_busy),
    .cur_dom   (cur_dom)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic op, logic [3:0] m, logic [31:0] c, bit pa,
                              int xs, int e3, int e2, int e1, int e0,
                              int dn, logic [3:0] fin);
    vec_t v;
    v.op = op; v.mask = m; v.cfg = c; v.pre_abort = pa; v.xs = xs;
    v.et[3] = (e3 < 0) ? NO : e3[15:0];
    v.et[2] = (e2 < 0) ? NO : e2[15:0];
    v.et[1] = (e1 < 0) ? NO : e1[15:0];
    v.et[0] = (e0 < 0) ? NO : e0[15:0];
    v.done_t = dn; v.fin = fin;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int ft[4], nchg[4];
    int dcnt, dfirst, bcnt, ecnt, efirst, ex;
    logic [3:0] prev;
    dcnt = 0; dfirst = -1; bcnt = 0; ecnt = 0; efirst = -1;
    for (int i = 0; i < 4; i++) begin ft[i] = -1; nchg[i] = 0; end
    if (v.pre_abort) begin
      seq_abort = 1'b1; tick(); seq_abort = 1'b0;
    end
    seq_start = 1'b1; seq_op = v.op; en_mask = v.mask; dly_cfg = v.cfg;
    prev = dom_rst_n;
    for (int e = 0; e <= v.done_t + 3; e++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (dom_rst_n[i] != prev[i]) begin
          if (ft[i] < 0) ft[i] = e;
          nchg[i]++;
          chk($sformatf("vec%0d_cur_dom_at_bit%0d", n, i), int'(cur_dom), i);
        end
      end
      prev = dom_rst_n;
      if (done) begin dcnt++; dfirst = e; end
      if (busy) bcnt++;
      if (err_busy) begin ecnt++; efirst = e; end
      seq_start = (e + 1 == v.xs);
      seq_op    = 1'($urandom);
      en_mask   = 4'($urandom);
      dly_cfg   = $urandom;
    end
    seq_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex = (v.et[i] == NO) ? -1 : int'(v.et[i]);
      chk($sformatf("vec%0d_bit%0d_edge", n, i), ft[i], ex);
      chk($sformatf("vec%0d_bit%0d_changes", n, i), nchg[i], (ex < 0) ? 0 : 1);
    end
    chk($sformatf("vec%0d_done_count", n), dcnt, 1);
    chk($sformatf("vec%0d_done_edge", n), dfirst, v.done_t);
    chk($sformatf("vec%0d_busy_cycles", n), bcnt, v.done_t);
    chk($sformatf("vec%0d_err_count", n), ecnt, (v.xs >= 0) ? 1 : 0);
    if (v.xs >= 0) chk($sformatf("vec%0d_err_edge", n), efirst, v.xs);
    chk($sformatf("vec%0d_final_dom", n), int'(dom_rst_n), int'(v.fin));
  endtask

  task automatic chk_all(input string nm, input int d, input int b, input int dn,
                         input int er, input int cd);
    chk({nm, "_dom"}, int'(dom_rst_n), d);
    chk({nm, "_busy"}, int'(busy), b);
    chk({nm, "_done"}, int'(done), dn);
    chk({nm, "_err"}, int'(err_busy), er);
    chk({nm, "_cur"}, int'(cur_dom), cd);
  endtask

  // Randomized sequences; expectations come from a per-domain schedule:
  // each domain owns a slot starting at ps[i] of length dly+2 (enabled) or 1.
  task automatic run_random(input int iters);
    logic [3:0] mdom, mask, ed;
    logic [7:0] dl[4];
    logic       op;
    int ps[4], pe[4];
    int p, L, a, i, eb, edn, eer, ecur, pbusy;
    bit xs[128];
    seq_abort = 1'b1; tick(); seq_abort = 1'b0;
    mdom = '0;
    for (int it = 0; it < iters; it++) begin
      op   = 1'($urandom_range(0, 1));
      mask = 4'($urandom);
      for (int k = 0; k < 4; k++)
        dl[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20))
                                            : 8'($urandom_range(0, 4));
      p = 1;
      for (int k = 0; k < 4; k++) begin
        i = op ? 3 - k : k;
        ps[i] = p;
        pe[i] = p + (mask[i] ? int'(dl[i]) + 2 : 1);
        p = pe[i];
      end
      L = p;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, L)) : -1;
      for (int e = 0; e < 128; e++) xs[e] = 1'b0;
      for (int e = 1; e <= L; e++)
        if ($urandom_range(0, 5) == 0 && (a < 0 || e <= a)) xs[e] = 1'b1;
      seq_start = 1'b1; seq_op = op; en_mask = mask;
      dly_cfg = {dl[3], dl[2], dl[1], dl[0]};
      for (int e = 0; e <= L + 3; e++) begin
        tick();
        if (a >= 0 && e >= a) begin
          ed = '0; eb = 0; edn = 0; ecur = 0;
        end else begin
          ed = mdom;
          for (int j = 0; j < 4; j++) if (mask[j] && e >= ps[j]) ed[j] = ~op;
          eb = (e <= L - 1) ? 1 : 0;
          edn = (e == L) ? 1 : 0;
          ecur = 0;
          for (int j = 0; j < 4; j++) if (e >= ps[j] - 1 && e <= pe[j] - 2) ecur = j;
        end
        pbusy = (e >= 1 && e - 1 <= L - 1 && !(a >= 0 && e - 1 >= a)) ? 1 : 0;
        eer = (xs[e] && pbusy == 1 && a != e) ? 1 : 0;
        chk_all($sformatf("rnd%0d_e%0d", it, e), int'(ed), eb, edn, eer, ecur);
        seq_start = (e + 1 < 128) ? xs[e + 1] : 1'b0;
        seq_abort = (a == e + 1);
        seq_op    = 1'($urandom);
        en_mask   = 4'($urandom);
        dly_cfg   = $urandom;
      end
      seq_start = 1'b0; seq_abort = 1'b0;
      if (a >= 0) mdom = '0;
      else for (int j = 0; j < 4; j++) if (mask[j]) mdom[j] = ~op;
    end
  endtask

  initial begin
    vec_t v;
    int dcnt, bcnt;
    vt[0]  = mk(1'b0, 4'b1111, {8'd1, 8'd5, 8'd0, 8'd3}, 1'b1, -1, 15, 8, 6, 1, 18, 4'b1111);
    vt[1]  = mk(1'b0, 4'b0101, 32'h02020202,              1'b1, -1, -1, 6, -1, 1, 11, 4'b0101);
    vt[2]  = mk(1'b0, 4'b1111, 32'h00000000,              1'b1, -1,  7, 5, 3, 1,  9, 4'b1111);
    vt[3]  = mk(1'b1, 4'b1111, 32'h00000000,              1'b0, -1,  1, 3, 5, 7,  9, 4'b0000);
    vt[4]  = mk(1'b1, 4'b1111, {8'd1, 8'd5, 8'd0, 8'd3}, 1'b0, -1, -1, -1, -1, -1, 18, 4'b0000);
    vt[5]  = mk(1'b0, 4'b0000, 32'h07070707,              1'b0, -1, -1, -1, -1, -1,  5, 4'b0000);
    vt[6]  = mk(1'b0, 4'b1111, 32'h01010101,              1'b0, -1, 10, 7, 4, 1, 13, 4'b1111);
    vt[7]  = mk(1'b1, 4'b1010, {8'd7, 8'd0, 8'd2, 8'd0}, 1'b0, -1,  1, -1, 11, -1, 16, 4'b0101);
    vt[8]  = mk(1'b0, 4'b1111, {8'd1, 8'd5, 8'd0, 8'd3}, 1'b1,  3, 15, 8, 6, 1, 18, 4'b1111);
    vt[9]  = mk(1'b0, 4'b0001, 32'h000000FF,              1'b1, -1, -1, -1, -1, 1, 261, 4'b0001);
    vt[10] = mk(1'b1, 4'b1000, 32'h00000000,              1'b0, -1, -1, -1, -1, -1, 6, 4'b0001);

    #2 rst_n = 1'b0;
    #8;
    chk_all("reset", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 11; n++) run_vec(vt[n], n);

    // Abort in WAIT of domain 1, with a simultaneous start that must be ignored
    seq_abort = 1'b1; tick(); seq_abort = 1'b0;
    seq_start = 1'b1; seq_op = 1'b0; en_mask = 4'b1111;
    dly_cfg = {8'd1, 8'd5, 8'd0, 8'd3};
    for (int e = 0; e <= 6; e++) begin tick(); seq_start = 1'b0; end
    chk("abort_pre_dom", int'(dom_rst_n), 3);
    chk("abort_pre_cur", int'(cur_dom), 1);
    seq_abort = 1'b1; seq_start = 1'b1;
    tick();
    seq_abort = 1'b0; seq_start = 1'b0;
    chk_all("abort_post", 0, 0, 0, 0, 0);
    dcnt = 0; bcnt = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (done) dcnt++;
      if (busy || dom_rst_n != 4'b0000) bcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_stays_idle", bcnt, 0);

    // Asynchronous reset in the middle of a long delay
    seq_start = 1'b1; seq_op = 1'b0; en_mask = 4'b1111; dly_cfg = 32'hFFFFFFFF;
    for (int e = 0; e <= 10; e++) begin tick(); seq_start = 1'b0; end
    chk("rst_mid_pre_dom", int'(dom_rst_n), 1);
    chk("rst_mid_pre_busy", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    v = vt[0];
    v.pre_abort = 1'b0;
    run_vec(v, 100);

    run_random(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter N_DOM, default 4, meaning number of sequenced reset domains.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of each per-domain delay field.
REQ-003 SHALL have port CRCU_CLK  input  1  the single block clock.
REQ-004 SHALL have port CRCU_RST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port seq_start  input  1  one-cycle request to start a sequence.
REQ-006 SHALL have port seq_op  input  1  sequence direction: 0 = release (up), 1 = assert (down).
REQ-007 SHALL have port seq_abort  input  1  forces all domains into reset.
REQ-008 SHALL have port en_mask  input  N_DOM  domains taking part in the sequence.
REQ-009 SHALL have port dly_cfg  input  N_DOM*CNT_W  per-domain post-step delay; field i is bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port dom_rst_n  output  N_DOM  active-low domain resets.
REQ-011 SHALL have port busy  output  1  sequence in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-013 SHALL have port err_busy  output  1  one-cycle pulse when seq_start arrives while busy.
REQ-014 SHALL have port cur_dom  output  clog2(N_DOM)  index of the domain currently being stepped.

Function
REQ-015 SHALL implement the FSM states IDLE, STEP, WAIT and DONE.
REQ-016 IDLE with seq_start=1 SHALL capture seq_op, en_mask and dly_cfg into shadow registers, go to STEP and assert busy from the next cycle.
REQ-017 Start index SHALL be 0 ascending for op=0 and N_DOM-1 descending for op=1.
REQ-018 STEP with an enabled domain SHALL set dom_rst_n[idx] (op=0) or clear it (op=1) on the same edge, load the counter with the shadow delay of idx, and go to WAIT.
REQ-019 STEP with a disabled domain SHALL leave dom_rst_n unchanged, spend exactly one cycle, then advance idx, or go to DONE if idx is last.
REQ-020 WAIT SHALL decrement the counter while it is non-zero; at zero it SHALL advance idx and go to STEP, or go to DONE if idx is last.
REQ-021 Consecutive enabled-domain edges SHALL be spaced exactly dly+2 cycles, where dly is the delay of the earlier domain; dly=0 SHALL give 2 cycles.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; busy SHALL deassert on the DONE-to-IDLE edge.
REQ-023 seq_start while not IDLE SHALL be ignored and SHALL pulse err_busy for one cycle; the sequence SHALL continue unaffected.
REQ-024 seq_abort in any state SHALL clear all dom_rst_n on the next edge, go to IDLE and drop busy, with no done pulse.
REQ-025 seq_abort SHALL have priority over a simultaneous seq_start.
REQ-026 Changes on en_mask or dly_cfg during a sequence SHALL have no effect until the next start.
REQ-027 A step SHALL drive its value even if the domain is already at that value; the full delay SHALL still be spent.
REQ-028 cur_dom SHALL show idx in STEP and WAIT and SHALL be 0 in IDLE.
REQ-029 A counter at its maximum (2^CNT_W-1) SHALL NOT wrap; it SHALL count down normally.
REQ-030 Domains not stepped SHALL hold their previous dom_rst_n value.

Reset
REQ-031 CRCU_RST low SHALL asynchronously force state IDLE, dom_rst_n all 0, busy 0, done 0, err_busy 0, cur_dom 0, counter 0 and shadow registers 0.
REQ-032 Reset taken mid-sequence SHALL leave no residual state; the first start after reset SHALL behave as from power-on.

Structure
REQ-033 A shared package crcu_rst_seq_pkg SHALL hold the state enum, the op encoding constants (OP_UP=0, OP_DOWN=1) and the default values of N_DOM and CNT_W.
REQ-034 The loadable down-counter SHALL be a sub-module rst_seq_timer (ports: load, load_val, cnt_zero).
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Power-up test: en_mask=4'b1111, delays {3,0,5,1} for domains 0..3, op=0 -> dom_rst_n bits 0,1,2,3 rise at cycles t+1, t+1+5, t+1+7, t+1+14; done fires 3 cycles after bit 3 rises.
REQ-037 Skip test: en_mask=4'b0101, all delays 2, op=0 -> only bits 0 and 2 rise, 5 cycles apart; bits 1 and 3 stay 0; one done pulse.
REQ-038 Power-down test: op=1 from all-released, delays 0 -> bits 3,2,1,0 fall in order 2 cycles apart; cur_dom reads 3,2,1,0.
REQ-039 Abort test: seq_abort in WAIT of domain 1 during power-up -> dom_rst_n=0 next cycle, busy=0, no done; seq_start in the same cycle as seq_abort is ignored.
REQ-040 Busy test: seq_start in WAIT -> err_busy pulses once; sequence timing identical to REQ-036.
REQ-041 Reset test: assert CRCU_RST mid-WAIT with delay 255 -> all outputs at reset values immediately; a new start then completes normally.
